// File: rtl/regfile_pkg.sv
// Shared register-file types and constants for the RV32E write-back scheduler.
// The forwarding option is selected by the WB_BYPASS_EN macro in regfile_wb_sched.
package regfile_pkg;

    localparam int DATA_W   = 32;
    localparam int NUM_REGS = 16;
    localparam int REG_AW   = 4;

    typedef logic [REG_AW-1:0] reg_idx_t;
    typedef logic [DATA_W-1:0] reg_data_t;

    localparam reg_idx_t ZERO_REG = 4'd0;

    // True when a non-x0 source index names the given register.
    function automatic logic src_hits(input reg_idx_t src, input reg_idx_t dst);
        return (src != ZERO_REG) && (src == dst);
    endfunction

endpackage

// File: rtl/regfile_wb_sched_rr_arb2.sv
// Two-requester round-robin arbiter; bit 0 is execute, bit 1 is load return.
// The pointer records whether execute won the last grant.
module rr_arb2 (
    input  logic       clk,
    input  logic       rst_n,
    input  logic [1:0] req,
    output logic [1:0] gnt
);

    logic ex_last_q;
    logic ex_last_d;

    // Grant logic: a lone requester wins, on contention the previous winner yields.
    always_comb begin
        gnt       = 2'b00;
        ex_last_d = ex_last_q;
        if (!rst_n) begin
            gnt = 2'b00;
        end else if (req == 2'b11) begin
            gnt = ex_last_q ? 2'b10 : 2'b01;
        end else begin
            gnt = req;
        end
        if (gnt != 2'b00) begin
            ex_last_d = gnt[0];
        end else begin
            ex_last_d = ex_last_q;
        end
    end

    // Pointer register, cleared so execute is favoured first.
    always_ff @(posedge clk) begin
        if (!rst_n) begin
            ex_last_q <= 1'b0;
        end else begin
            ex_last_q <= ex_last_d;
        end
    end

endmodule

// File: rtl/regfile_wb_sched.sv
// Register-file write-port scheduler and load scoreboard for RV32E.
// Define WB_BYPASS_EN to add forwarding ports in place of the in-flight-write stall.
module regfile_wb_sched
    import regfile_pkg::*;
(
    input  logic                clk,
    input  logic                rst_n,
    input  logic                ex_valid,
    input  logic [REG_AW-1:0]   ex_rd,
    input  logic [DATA_W-1:0]   ex_data,
    output logic                ex_ready,
    input  logic                ld_valid,
    input  logic [REG_AW-1:0]   ld_rd,
    input  logic [DATA_W-1:0]   ld_data,
    output logic                ld_ready,
    input  logic                ld_issue,
    input  logic [REG_AW-1:0]   ld_issue_rd,
    input  logic [REG_AW-1:0]   rs1,
    input  logic [REG_AW-1:0]   rs2,
    output logic                stall,
    output logic [NUM_REGS-1:0] busy,
    output logic                issue_err,
    output logic                rf_wr_en,
    output logic [REG_AW-1:0]   rf_wr_reg,
    output logic [DATA_W-1:0]   rf_wr_value
`ifdef WB_BYPASS_EN
    ,
    output logic                fwd1_en,
    output logic [DATA_W-1:0]   fwd1_data,
    output logic                fwd2_en,
    output logic [DATA_W-1:0]   fwd2_data
`endif
);

    logic [NUM_REGS-1:0] busy_q, busy_d;
    logic                issue_err_q, issue_err_d;
    logic                wr_en_q, wr_en_d;
    reg_idx_t            wr_reg_q, wr_reg_d;
    reg_data_t           wr_val_q, wr_val_d;
    logic [1:0]          req_s, gnt_s;
    reg_idx_t            sel_rd_s;
    reg_data_t           sel_data_s;

    // An execute write to a register with a load outstanding waits, keeping WAW order.
    assign req_s = {ld_valid, ex_valid & ~busy_q[ex_rd]};

    rr_arb2 u_arb (
        .clk   (clk),
        .rst_n (rst_n),
        .req   (req_s),
        .gnt   (gnt_s)
    );

    assign ex_ready = gnt_s[0];
    assign ld_ready = gnt_s[1];

    // Next-state for the write register, scoreboard and sticky issue error.
    always_comb begin
        sel_rd_s   = ZERO_REG;
        sel_data_s = 32'd0;
        if (gnt_s[0]) begin
            sel_rd_s   = ex_rd;
            sel_data_s = ex_data;
        end else if (gnt_s[1]) begin
            sel_rd_s   = ld_rd;
            sel_data_s = ld_data;
        end else begin
            sel_rd_s   = ZERO_REG;
            sel_data_s = 32'd0;
        end

        wr_en_d  = (gnt_s != 2'b00) && (sel_rd_s != ZERO_REG);
        wr_reg_d = wr_reg_q;
        wr_val_d = wr_val_q;
        if (wr_en_d) begin
            wr_reg_d = sel_rd_s;
            wr_val_d = sel_data_s;
        end else begin
            wr_reg_d = wr_reg_q;
            wr_val_d = wr_val_q;
        end

        busy_d = busy_q;
        if (gnt_s[1]) begin
            busy_d[ld_rd] = 1'b0;
        end else begin
            busy_d = busy_q;
        end
        if (ld_issue && (ld_issue_rd != ZERO_REG)) begin
            busy_d[ld_issue_rd] = 1'b1;
        end else begin
            busy_d[0] = 1'b0;
        end
        busy_d[0] = 1'b0;

        // A re-issue to a register whose load returns this same cycle is legal.
        issue_err_d = issue_err_q
                    | (ld_issue && (ld_issue_rd != ZERO_REG) && busy_q[ld_issue_rd]
                       && !(gnt_s[1] && (ld_rd == ld_issue_rd)));
    end

    // State registers; reset drops any write granted in the same cycle.
    always_ff @(posedge clk) begin
        if (!rst_n) begin
            busy_q      <= 16'd0;
            issue_err_q <= 1'b0;
            wr_en_q     <= 1'b0;
            wr_reg_q    <= 4'd0;
            wr_val_q    <= 32'd0;
        end else begin
            busy_q      <= busy_d;
            issue_err_q <= issue_err_d;
            wr_en_q     <= wr_en_d;
            wr_reg_q    <= wr_reg_d;
            wr_val_q    <= wr_val_d;
        end
    end

    assign busy        = busy_q;
    assign issue_err   = issue_err_q;
    assign rf_wr_en    = wr_en_q;
    assign rf_wr_reg   = wr_reg_q;
    assign rf_wr_value = wr_val_q;

`ifdef WB_BYPASS_EN
    assign fwd1_en   = wr_en_q && src_hits(rs1, wr_reg_q);
    assign fwd2_en   = wr_en_q && src_hits(rs2, wr_reg_q);
    assign fwd1_data = wr_val_q;
    assign fwd2_data = wr_val_q;
    assign stall     = ((rs1 != ZERO_REG) && busy_q[rs1]) || ((rs2 != ZERO_REG) && busy_q[rs2]);
`else
    // The write in flight is not yet readable from the register file.
    assign stall = ((rs1 != ZERO_REG) && busy_q[rs1]) || ((rs2 != ZERO_REG) && busy_q[rs2])
                 || (wr_en_q && (src_hits(rs1, wr_reg_q) || src_hits(rs2, wr_reg_q)));
`endif

endmodule

// File: tb/tb_regfile_wb_sched.sv
// Self-checking bench for regfile_wb_sched: directed scenarios plus randomized traffic
// against a behavioural model. Honours WB_BYPASS_EN like the design.
module tb_regfile_wb_sched;

    logic        clk = 1'b0;
    logic        rst_n;
    logic        ex_valid, ld_valid, ld_issue;
    logic [3:0]  ex_rd, ld_rd, ld_issue_rd, rs1, rs2;
    logic [31:0] ex_data, ld_data;
    logic        ex_ready, ld_ready, stall, issue_err, rf_wr_en;
    logic [15:0] busy;
    logic [3:0]  rf_wr_reg;
    logic [31:0] rf_wr_value;
`ifdef WB_BYPASS_EN
    logic        fwd1_en, fwd2_en;
    logic [31:0] fwd1_data, fwd2_data;
`endif

    int n_checks = 0;
    int n_pass   = 0;

    always #5 clk = ~clk;

    regfile_wb_sched dut (
        .clk(clk), .rst_n(rst_n),
        .ex_valid(ex_valid), .ex_rd(ex_rd), .ex_data(ex_data), .ex_ready(ex_ready),
        .ld_valid(ld_valid), .ld_rd(ld_rd), .ld_data(ld_data), .ld_ready(ld_ready),
        .ld_issue(ld_issue), .ld_issue_rd(ld_issue_rd), .rs1(rs1), .rs2(rs2),
        .stall(stall), .busy(busy), .issue_err(issue_err),
        .rf_wr_en(rf_wr_en), .rf_wr_reg(rf_wr_reg), .rf_wr_value(rf_wr_value)
`ifdef WB_BYPASS_EN
        , .fwd1_en(fwd1_en), .fwd1_data(fwd1_data), .fwd2_en(fwd2_en), .fwd2_data(fwd2_data)
`endif
    );

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic idle();
        ex_valid = 1'b0; ex_rd = 4'd0; ex_data = 32'd0;
        ld_valid = 1'b0; ld_rd = 4'd0; ld_data = 32'd0;
        ld_issue = 1'b0; ld_issue_rd = 4'd0; rs1 = 4'd0; rs2 = 4'd0;
    endtask

    task automatic test_reset();
        rst_n = 1'b0;
        ex_valid = 1'b1; ex_rd = 4'd6; ex_data = 32'hA5A5A5A5;
        ld_valid = 1'b1; ld_rd = 4'd8; ld_data = 32'h5A5A5A5A;
        ld_issue = 1'b1; ld_issue_rd = 4'd3; rs1 = 4'd0; rs2 = 4'd0;
        #1;
        n_checks++;
        if ({ex_ready, ld_ready} !== 2'b00) $display("FAIL reset_ready: got %b want 00", {ex_ready, ld_ready});
        else n_pass++;
        tick();
        tick();
        n_checks++;
        if (rf_wr_en !== 1'b0 || busy !== 16'd0 || issue_err !== 1'b0)
            $display("FAIL reset_state: wr_en=%b busy=%h err=%b want 0/0000/0", rf_wr_en, busy, issue_err);
        else n_pass++;
        idle();
        rst_n = 1'b1;
        tick();
    endtask

    task automatic test_single_ex();
        idle();
        ex_valid = 1'b1; ex_rd = 4'd5; ex_data = 32'hDEADBEEF;
        #1;
        n_checks++;
        if (ex_ready !== 1'b1) $display("FAIL single_ready: got %b want 1", ex_ready);
        else n_pass++;
        tick();
        idle();
        n_checks++;
        if (rf_wr_en !== 1'b1 || rf_wr_reg !== 4'd5 || rf_wr_value !== 32'hDEADBEEF)
            $display("FAIL single_write: got en=%b reg=%0d val=%h want 1/5/deadbeef", rf_wr_en, rf_wr_reg, rf_wr_value);
        else n_pass++;
        tick();
        n_checks++;
        if (rf_wr_en !== 1'b0 || rf_wr_reg !== 4'd5) $display("FAIL single_pulse: got en=%b reg=%0d want 0/5", rf_wr_en, rf_wr_reg);
        else n_pass++;
    endtask

    task automatic test_contention();
        test_reset();
        ex_valid = 1'b1; ex_rd = 4'd3; ex_data = 32'h33;
        ld_valid = 1'b1; ld_rd = 4'd4; ld_data = 32'h44;
        for (int i = 0; i < 4; i++) begin
            #1;
            n_checks++;
            if ({ld_ready, ex_ready} !== ((i % 2 == 0) ? 2'b01 : 2'b10))
                $display("FAIL contention_grant%0d: got ld/ex=%b%b", i, ld_ready, ex_ready);
            else n_pass++;
            tick();
            n_checks++;
            if (rf_wr_en !== 1'b1 || rf_wr_reg !== ((i % 2 == 0) ? 4'd3 : 4'd4))
                $display("FAIL contention_reg%0d: got en=%b reg=%0d", i, rf_wr_en, rf_wr_reg);
            else n_pass++;
        end
        idle();
        tick();
    endtask

    task automatic test_scoreboard();
        idle();
        ld_issue = 1'b1; ld_issue_rd = 4'd7;
        tick();
        ld_issue = 1'b0; rs1 = 4'd7;
        ex_valid = 1'b1; ex_rd = 4'd7; ex_data = 32'h77;
        #1;
        n_checks++;
        if (busy[7] !== 1'b1 || stall !== 1'b1 || ex_ready !== 1'b0)
            $display("FAIL sb_hazard: got busy7=%b stall=%b ex_ready=%b want 1/1/0", busy[7], stall, ex_ready);
        else n_pass++;
        tick();
        ld_valid = 1'b1; ld_rd = 4'd7; ld_data = 32'h1D;
        #1;
        n_checks++;
        if (ld_ready !== 1'b1 || ex_ready !== 1'b0) $display("FAIL sb_ld_grant: got ld=%b ex=%b want 1/0", ld_ready, ex_ready);
        else n_pass++;
        tick();
        ld_valid = 1'b0;
        #1;
        n_checks++;
        if (busy[7] !== 1'b0 || rf_wr_value !== 32'h1D || ex_ready !== 1'b1)
            $display("FAIL sb_release: got busy7=%b val=%h ex_ready=%b want 0/1d/1", busy[7], rf_wr_value, ex_ready);
        else n_pass++;
        tick();
        idle();
        n_checks++;
        if (rf_wr_reg !== 4'd7 || rf_wr_value !== 32'h77) $display("FAIL sb_ex_write: got reg=%0d val=%h want 7/77", rf_wr_reg, rf_wr_value);
        else n_pass++;
    endtask

    task automatic test_set_clear();
        idle();
        ld_issue = 1'b1; ld_issue_rd = 4'd9;
        tick();
        ld_valid = 1'b1; ld_rd = 4'd9; ld_data = 32'h99;
        tick();
        idle();
        n_checks++;
        if (busy[9] !== 1'b1 || issue_err !== 1'b0) $display("FAIL setclr_busy: got busy9=%b err=%b want 1/0", busy[9], issue_err);
        else n_pass++;
        ld_issue = 1'b1; ld_issue_rd = 4'd9;
        tick();
        idle();
        tick();
        tick();
        n_checks++;
        if (issue_err !== 1'b1 || busy[9] !== 1'b1) $display("FAIL setclr_err: got err=%b busy9=%b want 1/1", issue_err, busy[9]);
        else n_pass++;
        ld_valid = 1'b1; ld_rd = 4'd9;
        tick();
        idle();
    endtask

    task automatic test_x0_bypass();
        idle();
        ex_valid = 1'b1; ex_rd = 4'd0; ex_data = 32'hFFFF;
        #1;
        n_checks++;
        if (ex_ready !== 1'b1) $display("FAIL x0_ready: got %b want 1", ex_ready);
        else n_pass++;
        tick();
        n_checks++;
        if (rf_wr_en !== 1'b0) $display("FAIL x0_noWrite: got %b want 0", rf_wr_en);
        else n_pass++;
        ex_rd = 4'd2; ex_data = 32'h1234;
        tick();
        idle();
        rs1 = 4'd2;
        #1;
        n_checks++;
`ifdef WB_BYPASS_EN
        if (rf_wr_en !== 1'b1 || fwd1_en !== 1'b1 || fwd1_data !== 32'h1234 || stall !== 1'b0)
            $display("FAIL bypass: got en=%b fwd=%b data=%h stall=%b want 1/1/1234/0", rf_wr_en, fwd1_en, fwd1_data, stall);
        else n_pass++;
`else
        if (rf_wr_en !== 1'b1 || stall !== 1'b1) $display("FAIL inflight_stall: got en=%b stall=%b want 1/1", rf_wr_en, stall);
        else n_pass++;
`endif
        tick();
        n_checks++;
        if (stall !== 1'b0) $display("FAIL inflight_clear: got stall=%b want 0", stall);
        else n_pass++;
    endtask

    task automatic test_random();
        bit          m_busy[16];
        bit          m_err;
        bit          ex_has_priority;
        bit          m_en;
        logic [3:0]  m_reg;
        logic [31:0] m_val;
        logic [15:0] m_busy_vec;
        bit          ex_ok, want_ex, want_ld, m_stall, m_bypass;
        test_reset();
        foreach (m_busy[k]) m_busy[k] = 1'b0;
        m_err = 1'b0; ex_has_priority = 1'b1; m_en = 1'b0; m_reg = 4'd0; m_val = 32'd0;
`ifdef WB_BYPASS_EN
        m_bypass = 1'b1;
`else
        m_bypass = 1'b0;
`endif
        for (int c = 0; c < 300; c++) begin
            ex_valid = 1'($urandom_range(0, 1)); ex_rd = 4'($urandom_range(0, 7)); ex_data = $urandom;
            ld_valid = ($urandom_range(0, 2) == 0); ld_rd = 4'($urandom_range(0, 7)); ld_data = $urandom;
            ld_issue = ($urandom_range(0, 3) == 0); ld_issue_rd = 4'($urandom_range(0, 7));
            rs1 = 4'($urandom_range(0, 7)); rs2 = 4'($urandom_range(0, 7));
            #1;
            ex_ok   = ex_valid && !m_busy[ex_rd];
            want_ex = ex_ok && (!ld_valid || ex_has_priority);
            want_ld = ld_valid && !want_ex;
            m_stall = (rs1 != 0 && m_busy[rs1]) || (rs2 != 0 && m_busy[rs2])
                   || (!m_bypass && m_en && ((rs1 != 0 && rs1 == m_reg) || (rs2 != 0 && rs2 == m_reg)));
            foreach (m_busy[k]) m_busy_vec[k] = m_busy[k];
            n_checks++;
            if (ex_ready !== want_ex || ld_ready !== want_ld || stall !== m_stall || busy !== m_busy_vec)
                $display("FAIL rand_comb c%0d: got ex=%b ld=%b stall=%b busy=%h want %b/%b/%b/%h",
                         c, ex_ready, ld_ready, stall, busy, want_ex, want_ld, m_stall, m_busy_vec);
            else n_pass++;
`ifdef WB_BYPASS_EN
            n_checks++;
            if (fwd1_en !== (m_en && rs1 != 0 && rs1 == m_reg) || fwd2_en !== (m_en && rs2 != 0 && rs2 == m_reg))
                $display("FAIL rand_fwd c%0d: got %b%b", c, fwd1_en, fwd2_en);
            else n_pass++;
`endif
            if (want_ex) ex_has_priority = 1'b0;
            if (want_ld) ex_has_priority = 1'b1;
            m_en = 1'b0;
            if (want_ex && ex_rd != 0) begin m_en = 1'b1; m_reg = ex_rd; m_val = ex_data; end
            if (want_ld && ld_rd != 0) begin m_en = 1'b1; m_reg = ld_rd; m_val = ld_data; end
            if (ld_issue && ld_issue_rd != 0 && m_busy[ld_issue_rd] && !(want_ld && ld_rd == ld_issue_rd)) m_err = 1'b1;
            if (want_ld) m_busy[ld_rd] = 1'b0;
            if (ld_issue && ld_issue_rd != 0) m_busy[ld_issue_rd] = 1'b1;
            tick();
            n_checks++;
            if (rf_wr_en !== m_en || rf_wr_reg !== m_reg || rf_wr_value !== m_val || issue_err !== m_err)
                $display("FAIL rand_seq c%0d: got en=%b reg=%0d val=%h err=%b want %b/%0d/%h/%b",
                         c, rf_wr_en, rf_wr_reg, rf_wr_value, issue_err, m_en, m_reg, m_val, m_err);
            else n_pass++;
        end
        idle();
    endtask

    initial begin
        idle();
        rst_n = 1'b0;
        tick();
        test_reset();
        test_single_ex();
        test_contention();
        test_scoreboard();
        test_set_clear();
        test_x0_bypass();
        test_random();
        test_reset();
        $display("%0d/%0d checks passed", n_pass, n_checks);
        $finish;
    end

endmodule
